expr_recognizer: RTL and testbench

Character-serial recognizer for parenthesised arithmetic expressions; parametrised successor to the single-digit number/operator string checker. Consumes one 8-bit ASCII character per accepted cycle and reports whether the prefix received so far is a complete, well-formed expression. Supports multi-digit numbers, a configurable operator set, nested parentheses and blank separators. Sits behind the character source in the P1 string-checking datapath.

---
 rtl/expr_pkg.sv | 29 ++
 rtl/expr_char_class.sv | 29 ++
 rtl/expr_recognizer.sv | 121 ++++++++++++
 tb/tb_expr_recognizer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared types and character constants for the expression recognizer.
package expr_pkg;

  typedef enum logic [2:0] {
    EMPTY,
    OPND,
    NUM,
    AFTER,
    FAULT
  } state_e;

  typedef enum logic [2:0] {
    CC_DIGIT,
    CC_OP,
    CC_LPAR,
    CC_RPAR,
    CC_BLANK,
    CC_OTHER
  } char_class_e;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_LPAR  = 8'h28;
  localparam logic [7:0] CH_RPAR  = 8'h29;
  localparam logic [7:0] CH_BLANK = 8'h20;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier; disabled operators classify as other.
module expr_char_class
  import expr_pkg::*;
#(
  parameter int ALLOW_SUB = 1,
  parameter int ALLOW_DIV = 1
) (
  input  logic [7:0]  i_ch,
  output char_class_e o_cls
);

  always_comb begin
    o_cls = CC_OTHER;
    if (i_ch >= 8'h30 && i_ch <= 8'h39) begin
      o_cls = CC_DIGIT;
    end else begin
      case (i_ch)
        CH_PLUS, CH_STAR: o_cls = CC_OP;
        CH_MINUS:         if (ALLOW_SUB != 0) o_cls = CC_OP;
        CH_SLASH:         if (ALLOW_DIV != 0) o_cls = CC_OP;
        CH_LPAR:          o_cls = CC_LPAR;
        CH_RPAR:          o_cls = CC_RPAR;
        CH_BLANK:         o_cls = CC_BLANK;
        default:          o_cls = CC_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/expr_recognizer.sv
// Character-serial recognizer for parenthesised arithmetic expressions.
module expr_recognizer
  import expr_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 7,
  parameter int ALLOW_SUB  = 1,
  parameter int ALLOW_DIV  = 1,
  parameter int CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           sync_clr,
  input  logic                           in_valid,
  input  logic [7:0]                     in,
  output logic                           out,
  output logic                           fault,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic [CNT_W-1:0]               op_count
);

  localparam int DW  = $clog2(MAX_DEPTH + 1);
  localparam int DGW = $clog2(MAX_DIGITS + 1);

  state_e           r_state, w_state_nxt;
  logic [DW-1:0]    r_depth, w_depth_nxt;
  logic [DGW-1:0]   r_digits, w_digits_nxt;
  logic [CNT_W-1:0] r_ops, w_ops_nxt;
  char_class_e      w_cls;

  expr_char_class #(
    .ALLOW_SUB(ALLOW_SUB),
    .ALLOW_DIV(ALLOW_DIV)
  ) u_class (
    .i_ch (in),
    .o_cls(w_cls)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= EMPTY;
      r_depth  <= '0;
      r_digits <= '0;
      r_ops    <= '0;
    end else if (sync_clr) begin
      r_state  <= EMPTY;
      r_depth  <= '0;
      r_digits <= '0;
      r_ops    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_depth  <= w_depth_nxt;
      r_digits <= w_digits_nxt;
      r_ops    <= w_ops_nxt;
    end
  end

  // Counters only move on legal transitions, so entering FAULT freezes them.
  always_comb begin
    w_state_nxt  = r_state;
    w_depth_nxt  = r_depth;
    w_digits_nxt = r_digits;
    w_ops_nxt    = r_ops;
    if (in_valid) begin
      case (r_state)
        EMPTY, OPND: begin
          case (w_cls)
            CC_DIGIT: begin
              w_state_nxt  = NUM;
              w_digits_nxt = DGW'(1);
            end
            CC_LPAR: begin
              if (r_depth == DW'(MAX_DEPTH)) begin
                w_state_nxt = FAULT;
              end else begin
                w_state_nxt = OPND;
                w_depth_nxt = r_depth + 1'b1;
              end
            end
            CC_BLANK: w_state_nxt = r_state;
            default:  w_state_nxt = FAULT;
          endcase
        end
        NUM, AFTER: begin
          case (w_cls)
            CC_DIGIT: begin
              if (r_state == NUM && r_digits != DGW'(MAX_DIGITS)) begin
                w_digits_nxt = r_digits + 1'b1;
              end else begin
                w_state_nxt = FAULT;
              end
            end
            CC_OP: begin
              w_state_nxt = OPND;
              if (r_ops != '1) w_ops_nxt = r_ops + 1'b1;
            end
            CC_RPAR: begin
              if (r_depth == '0) begin
                w_state_nxt = FAULT;
              end else begin
                w_state_nxt = AFTER;
                w_depth_nxt = r_depth - 1'b1;
              end
            end
            CC_BLANK: w_state_nxt = AFTER;
            default:  w_state_nxt = FAULT;
          endcase
        end
        default: w_state_nxt = FAULT;
      endcase
    end
  end

  always_comb begin
    out      = (r_state == NUM || r_state == AFTER) && (r_depth == '0);
    fault    = (r_state == FAULT);
    depth    = r_depth;
    op_count = r_ops;
  end

endmodule

// File: tb/tb_expr_recognizer.sv
// Randomized bench: two parameterisations checked against a prefix-rescanning reference model.
module tb_expr_recognizer;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       sync_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;

  logic       a_out, a_fault;
  logic [2:0] a_depth;
  logic [7:0] a_ops;
  logic       b_out, b_fault;
  logic [1:0] b_depth;
  logic [2:0] b_ops;

  int total = 0;
  int bad   = 0;

  byte unsigned hist[$];

  typedef struct {
    bit flt;
    bit ok;
    int dep;
    int ops;
  } res_t;

  always #5 clk = ~clk;

  expr_recognizer #(
    .MAX_DIGITS(4), .MAX_DEPTH(7), .ALLOW_SUB(1), .ALLOW_DIV(1), .CNT_W(8)
  ) dut_a (
    .clk(clk), .clr(clr), .sync_clr(sync_clr), .in_valid(in_valid), .in(in),
    .out(a_out), .fault(a_fault), .depth(a_depth), .op_count(a_ops)
  );

  expr_recognizer #(
    .MAX_DIGITS(2), .MAX_DEPTH(2), .ALLOW_SUB(0), .ALLOW_DIV(0), .CNT_W(3)
  ) dut_b (
    .clk(clk), .clr(clr), .sync_clr(sync_clr), .in_valid(in_valid), .in(in),
    .out(b_out), .fault(b_fault), .depth(b_depth), .op_count(b_ops)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Re-scans the whole accepted prefix from scratch with the grammar rules.
  function automatic res_t model(input int md, input int mdep, input bit sub,
                                 input bit dv, input int cw);
    res_t r;
    int   lit = 0;
    bit   need = 1'b1;
    bit   closed = 1'b0;
    int   opmax = (1 << cw) - 1;
    r = '{1'b0, 1'b0, 0, 0};
    foreach (hist[i]) begin
      byte unsigned c;
      bit isop, term;
      c    = hist[i];
      isop = (c == "+") || (c == "*") || (c == "-" && sub) || (c == "/" && dv);
      term = (lit > 0) || closed;
      if (c >= "0" && c <= "9") begin
        if (need) begin lit = 1; need = 1'b0; end
        else if (lit > 0 && lit < md) lit++;
        else r.flt = 1'b1;
      end else if (isop) begin
        if (term) begin
          if (r.ops < opmax) r.ops++;
          need = 1'b1; lit = 0; closed = 1'b0;
        end else r.flt = 1'b1;
      end else if (c == "(") begin
        if (need && r.dep < mdep) r.dep++;
        else r.flt = 1'b1;
      end else if (c == ")") begin
        if (term && r.dep > 0) begin r.dep--; lit = 0; closed = 1'b1; end
        else r.flt = 1'b1;
      end else if (c == " ") begin
        if (lit > 0) begin lit = 0; closed = 1'b1; end
      end else begin
        r.flt = 1'b1;
      end
      if (r.flt) break;
    end
    r.ok = !r.flt && !need && (r.dep == 0);
    return r;
  endfunction

  task automatic check_all(input string tag);
    res_t ra, rb;
    ra = model(4, 7, 1'b1, 1'b1, 8);
    rb = model(2, 2, 1'b0, 1'b0, 3);
    check({tag, ".a.out"},   int'(a_out),   int'(ra.ok));
    check({tag, ".a.fault"}, int'(a_fault), int'(ra.flt));
    check({tag, ".a.depth"}, int'(a_depth), ra.dep);
    check({tag, ".a.ops"},   int'(a_ops),   ra.ops);
    check({tag, ".b.out"},   int'(b_out),   int'(rb.ok));
    check({tag, ".b.fault"}, int'(b_fault), int'(rb.flt));
    check({tag, ".b.depth"}, int'(b_depth), rb.dep);
    check({tag, ".b.ops"},   int'(b_ops),   rb.ops);
  endtask

  task automatic step(input byte unsigned ch, input bit v, input bit sc, input string tag);
    @(negedge clk);
    in_valid = v;
    in       = ch;
    sync_clr = sc;
    @(posedge clk);
    #1;
    if (sc) hist.delete();
    else if (v) hist.push_back(ch);
    in_valid = 1'b0;
    sync_clr = 1'b0;
    check_all(tag);
  endtask

  task automatic send(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0, tag);
  endtask

  task automatic pulse_clr(input string tag);
    @(negedge clk);
    #1 clr = 1'b0;
    hist.delete();
    #1 check_all(tag);
    #1 clr = 1'b1;
  endtask

  initial begin
    string pool;
    pool = "+-*/() a";
    #12 check_all("reset");
    clr = 1'b1;

    send("12+3", "seq1");
    check("seq1.ops_const", int'(a_ops), 1);
    check("seq1.out_const", int'(a_out), 1);
    step(8'h00, 1'b0, 1'b1, "sclr1");

    send("((7)*4", "nest");
    check("nest.out_depth1", int'(a_out), 0);
    send(")", "nest");
    check("nest.out_final", int'(a_out), 1);
    step(8'h00, 1'b0, 1'b1, "sclr2");

    send("12345", "digits");
    check("digits.fault_const", int'(a_fault), 1);
    step(8'h00, 1'b0, 1'b1, "sclr3");
    check("sclr3.fault_const", int'(a_fault), 0);
    send("1 2", "blank");
    step(8'h00, 1'b0, 1'b1, "sclr4");

    send("5-", "sub");
    check("sub.b_fault_const", int'(b_fault), 1);
    check("sub.a_ops_const", int'(a_ops), 1);
    step(8'h00, 1'b0, 1'b1, "sclr5");

    send("(((", "depth");
    check("depth.b_const", int'(b_depth), 2);
    step(8'h00, 1'b0, 1'b1, "sclr6");
    send(")", "rpar_empty");
    step(8'h00, 1'b0, 1'b1, "sclr7");

    step("8", 1'b1, 1'b0, "gap");
    step("+", 1'b0, 1'b0, "gap");
    step("+", 1'b0, 1'b0, "gap");
    step("+", 1'b1, 1'b0, "gap");
    pulse_clr("clr_mid");
    check("clr_mid.ops_const", int'(a_ops), 0);

    send("1+2+3+4+5+6+7+8+9", "sat");
    step(8'h00, 1'b0, 1'b1, "sclr8");

    for (int n = 0; n < 2000; n++) begin
      int unsigned r;
      byte unsigned ch;
      r = $urandom_range(0, 99);
      if (r < 50) ch = byte'($urandom_range(48, 57));
      else ch = pool[$urandom_range(0, pool.len() - 1)];
      if ($urandom_range(0, 99) < 2) pulse_clr("rnd_clr");
      else step(ch, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 4, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
